vout_dpi_tx: RTL and testbench
==============================

Name: vout_dpi_tx

Overview:
DPI video transmitter; the output-side counterpart of the board-level video input path.
- Consumes the same 4-pixel-per-clock Y8 stream format that the input path produces (32-bit word, valid/ready).
- Regenerates DPI timing (vsync/hsync/de) from parameterised counters and serialises one pixel per clock as grey RGB888.
- Used for loopback bring-up of the input path and for driving a DPI panel or monitor.

Parameters:
- H_ACTIVE, 1600: active pixels per line. Must be a multiple of 4 and ≥ 4.
- H_FP, 48: horizontal front porch, in clocks.
- H_SYNC, 32: hsync pulse width, in clocks.
- H_BP, 80: horizontal back porch, in clocks.
- V_ACTIVE, 1200: active lines per frame.
- V_FP, 3: vertical front porch, in lines.
- V_SYNC, 6: vsync pulse width, in lines.
- V_BP, 26: vertical back porch, in lines.
- HS_POL, 1'b0: asserted level of dpi_hsync.
- VS_POL, 1'b0: asserted level of dpi_vsync.

Ports:
- clk, input, 1: pixel clock. Single clock domain.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- en, input, 1: transmitter enable. Sampled only at frame boundary.
- s_pixel, input, 32: four Y8 pixels; bits [7:0] are sent first, bits [31:24] last.
- s_valid, input, 1: s_pixel holds a valid word.
- s_ready, output, 1: word is consumed this cycle when s_valid is also high.
- frame_start, output, 1: one-clock pulse at the start of each frame. Upstream uses it to flush or reset its FIFO.
- dpi_vsync, output, 1: vertical sync.
- dpi_hsync, output, 1: horizontal sync.
- dpi_de, output, 1: data enable.
- dpi_pixel, output, 24: {Y,Y,Y}.
- underflow, output, 1: sticky; set when an active fetch finds s_valid low.
- busy, output, 1: high while a frame is being transmitted.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt and v_cnt are sized with $clog2 of their totals.
- Horizontal region decode:
  - active: h_cnt in [0, H_ACTIVE).
  - front porch: h_cnt in [H_ACTIVE, H_ACTIVE+H_FP).
  - sync: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - back porch: remainder.
- Vertical decode uses the same regions on v_cnt, in lines.
- Counter wrap: h_cnt wraps at H_TOTAL-1 → 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1 → 0.
- State machine:
  - IDLE: counters held at 0; sync outputs at the deasserted level (~HS_POL / ~VS_POL); de=0; pixel=0; s_ready=0; busy=0. When en=1, go to RUN next cycle.
  - RUN: counters advance every clock; busy=1. On the last clock of the frame (h=H_TOTAL-1, v=V_TOTAL-1): if en=0, go to IDLE; else continue at h=v=0. Deasserting en mid-frame never truncates a frame.
- frame_start is registered. It pulses on the clock in which the counters are at h=0, v=0 in RUN, including the first frame after IDLE.
- Fetch and serialisation:
  - Phase = h_cnt[1:0].
  - s_ready = RUN && h_active && v_active && phase==0. It is combinational from the counters; it never depends on s_valid.
  - When s_ready && s_valid: the word is latched into the shift register.
  - When s_ready && !s_valid: the shift register loads 0 and underflow is set. The underflow line stays in the timing (no stall), with de=1 and pixel 0.
  - underflow is cleared only by rst_n.
- Output pipeline: all dpi_* outputs are registered, one clock after the counter state they describe. dpi_pixel at that clock = {Y,Y,Y}, where Y is byte [phase*8 +: 8] of the current word. For phase 0 the byte is taken from the incoming word directly.
- During blanking: dpi_de=0 and dpi_pixel=24'h0.
- Sync levels: dpi_hsync = HS_POL during the h sync region on any line. dpi_vsync = VS_POL during the v sync lines, for all h.
- Reset (async, rst_n=0): state IDLE; counters 0; all outputs 0 except dpi_hsync=~HS_POL and dpi_vsync=~VS_POL; underflow=0. Reset mid-frame aborts immediately; no partial line is completed.
- Words delivered by upstream outside s_ready windows are not consumed. The block consumes exactly H_ACTIVE/4 × V_ACTIVE words per frame.

Test Plan:
All tests use H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14) and V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7), unless stated.
1. Reset, en=0: all outputs at reset values. After en=1, busy=1 two clocks later. frame_start pulses once per 98 clocks. Each frame has 4 de runs of 8 clocks; hsync is low (HS_POL=0) for 2 clocks per line; vsync is low for exactly 14 clocks per frame.
2. Source always valid with word 0x44332211: each line outputs pixels 0x111111, 0x222222, 0x333333, 0x444444, twice. Exactly 8 words are consumed per frame; s_ready is never high in blanking; underflow stays 0.
3. s_valid dropped for the second fetch of line 2: that line's pixels 4–7 are 0 with de=1. underflow=1 and stays set into the following frames. Timing is unchanged.
4. en deasserted mid-frame 1: frame 1 completes all 98 clocks, then IDLE with busy=0 and no further frame_start. Re-enabling starts at h=v=0 with a frame_start pulse.
5. rst_n asserted at h=5, v=2: outputs return to reset values within the same clock (asynchronous). After release with en=1, the first frame is complete and correctly timed.
6. HS_POL=1, VS_POL=1: sync pulses are high for 2 clocks and 14 clocks respectively; idle sync levels are 0.

Source files
------------

// File: rtl/vout_dpi_tx_if.sv
// Valid/ready stream carrying four Y8 pixels per word into the DPI transmitter.
interface vout_dpi_tx_if;
  logic [31:0] pixel;
  logic        valid;
  logic        ready;

  modport master (output pixel, output valid, input ready);
  modport slave  (input pixel, input valid, output ready);
endinterface

// File: rtl/vout_dpi_tx.sv
// DPI video transmitter: regenerates vsync/hsync/de from frame counters and serialises
// a 4-pixel-per-clock Y8 stream into one grey RGB888 pixel per clock.
module vout_dpi_tx #(
  parameter int   H_ACTIVE = 1600,
  parameter int   H_FP     = 48,
  parameter int   H_SYNC   = 32,
  parameter int   H_BP     = 80,
  parameter int   V_ACTIVE = 1200,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 26,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  vout_dpi_tx_if.slave s,
  output logic         frame_start,
  output logic         dpi_vsync,
  output logic         dpi_hsync,
  output logic         dpi_de,
  output logic [23:0]  dpi_pixel,
  output logic         underflow,
  output logic         busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_FP_START   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_BP_START   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_FP_START   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_BP_START   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);

  // Serialisation relies on every active line starting on a word boundary.
  if (H_ACTIVE < 4 || (H_ACTIVE % 4) != 0) begin : g_bad_h_active
    $error("vout_dpi_tx: H_ACTIVE must be a multiple of 4 and at least 4");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_d;
  logic [HW-1:0]   h_cnt, h_d;
  logic [VW-1:0]   v_cnt, v_d;
  logic            frame_start_d;
  logic            run, h_last, v_last;
  logic            h_in_act, v_in_act, h_in_sync, v_in_sync, in_act;
  logic [1:0]      phase;
  logic [23:0]     word_q;
  logic [7:0]      y;

  assign run       = (state == RUN);
  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign h_in_act  = (h_cnt < H_FP_START);
  assign v_in_act  = (v_cnt < V_FP_START);
  assign h_in_sync = (h_cnt >= H_SYNC_START) && (h_cnt < H_BP_START);
  assign v_in_sync = (v_cnt >= V_SYNC_START) && (v_cnt < V_BP_START);
  assign in_act    = run && h_in_act && v_in_act;
  assign phase     = h_cnt[1:0];

  // Fetch window depends only on the counters, never on s.valid.
  assign s.ready = in_act && (phase == 2'd0);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    h_d     = h_cnt;
    v_d     = v_cnt;
    case (state)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (h_last) begin
          h_d = '0;
          v_d = v_last ? '0 : v_cnt + 1'b1;
          // en only matters on the last clock, so a frame is never cut short.
          if (v_last && !en) state_d = IDLE;
        end else begin
          h_d = h_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_start_d = (state_d == RUN) && (h_d == '0) && (v_d == '0);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_d;
      h_cnt       <= h_d;
      v_cnt       <= v_d;
      frame_start <= frame_start_d;
    end
  end

  // Phase 0 takes its byte straight off the stream; later phases read the held word.
  always_comb begin
    y = 8'h00;
    case (phase)
      2'd0: y = s.valid ? s.pixel[7:0] : 8'h00;
      2'd1: y = word_q[7:0];
      2'd2: y = word_q[15:8];
      2'd3: y = word_q[23:16];
      default: y = 8'h00;
    endcase
  end

  // NOTE: word_q is reset as well, so dpi_pixel can never carry X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      dpi_de    <= 1'b0;
      dpi_pixel <= '0;
      dpi_hsync <= ~HS_POL;
      dpi_vsync <= ~VS_POL;
      underflow <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy      <= run;
      dpi_de    <= in_act;
      dpi_pixel <= in_act ? {y, y, y} : 24'h0;
      dpi_hsync <= (run && h_in_sync) ? HS_POL : ~HS_POL;
      dpi_vsync <= (run && v_in_sync) ? VS_POL : ~VS_POL;
      if (s.ready) begin
        // A missed fetch keeps the timing and sends black for the whole word.
        word_q <= s.valid ? s.pixel[31:8] : 24'h0;
        if (!s.valid) underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vout_dpi_tx.sv
// Bench for vout_dpi_tx: frame-position reference model plus table vectors and
// directed sequences for enable, underflow, async reset and sync polarity.
module tb_vout_dpi_tx;

  localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2, HT = HA + HFP + HSW + HBP;
  localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1, VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;

  logic clk, rst_n, en;
  logic frame_start, dpi_vsync, dpi_hsync, dpi_de, underflow, busy;
  logic [23:0] dpi_pixel;
  logic p_frame_start, p_vsync, p_hsync, p_de, p_underflow, p_busy;
  logic [23:0] p_pixel;

  vout_dpi_tx_if src ();
  vout_dpi_tx_if src_p ();

  vout_dpi_tx #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s(src),
    .frame_start(frame_start), .dpi_vsync(dpi_vsync), .dpi_hsync(dpi_hsync),
    .dpi_de(dpi_de), .dpi_pixel(dpi_pixel), .underflow(underflow), .busy(busy)
  );

  vout_dpi_tx #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .en(en), .s(src_p),
    .frame_start(p_frame_start), .dpi_vsync(p_vsync), .dpi_hsync(p_hsync),
    .dpi_de(p_de), .dpi_pixel(p_pixel), .underflow(p_underflow), .busy(p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the frame is a flat position t in [0, FT); h and v follow by division.
  typedef struct packed {
    bit          run;
    int          t;
    logic [31:0] word;
    logic        fs, vs, hs, de, uf, busy;
    logic [23:0] pix;
  } mstate_t;

  localparam mstate_t M_RESET = '{run: 1'b0, t: 0, word: 32'h0, fs: 1'b0, vs: 1'b1,
                                  hs: 1'b1, de: 1'b0, uf: 1'b0, busy: 1'b0, pix: 24'h0};

  mstate_t m;

  function automatic mstate_t model_step(mstate_t ms, logic en_i, logic valid_i, logic [31:0] pix_i);
    mstate_t n;
    int h, v;
    logic act;
    logic [7:0] yb;
    n = ms;
    h = ms.t % HT;
    v = ms.t / HT;
    act = ms.run && h < HA && v < VA;
    yb = 8'h00;
    if (act) begin
      if (h % 4 == 0) begin
        n.word = valid_i ? pix_i : 32'h0;
        if (!valid_i) n.uf = 1'b1;
        yb = n.word[7:0];
      end else begin
        yb = ms.word[8*(h%4) +: 8];
      end
    end
    n.de   = act;
    n.pix  = {yb, yb, yb};
    n.hs   = !(ms.run && h >= HA + HFP && h < HA + HFP + HSW);
    n.vs   = !(ms.run && v >= VA + VFP && v < VA + VFP + VSW);
    n.busy = ms.run;
    if (!ms.run) begin
      if (en_i) begin
        n.run = 1'b1;
        n.t   = 0;
      end
    end else if (ms.t == FT - 1) begin
      n.t   = 0;
      n.run = en_i;
    end else begin
      n.t = ms.t + 1;
    end
    n.fs = n.run && n.t == 0;
    return n;
  endfunction

  function automatic logic model_ready(mstate_t ms);
    int h, v;
    h = ms.t % HT;
    v = ms.t / HT;
    return ms.run && h < HA && v < VA && (h % 4) == 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RESET;
    else        m <= model_step(m, en, src.valid, src.pixel);
  end

  always @(negedge clk) begin
    if (mon_on)
      check("cycle_vs_model",
            {frame_start, dpi_vsync, dpi_hsync, dpi_de, dpi_pixel, underflow, busy, src.ready},
            {m.fs, m.vs, m.hs, m.de, m.pix, m.uf, m.busy, model_ready(m)});
  end

  typedef struct {
    logic [31:0]      word;
    logic [3:0][23:0] exp;
  } vec_t;

  vec_t vec[4];

  task automatic wait_fs(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, frame_start, 1'b1);
  endtask

  // Entered at the negedge showing frame position 1; observes exactly one frame of outputs.
  task automatic measure_frame(input string tag);
    int fs_n, de_n, runs, run_len, hs_lo, vs_lo, rdy, took, hs_p, vs_p;
    logic prev_de;
    fs_n = 0; de_n = 0; runs = 0; run_len = 0; hs_lo = 0; vs_lo = 0;
    rdy = 0; took = 0; hs_p = 0; vs_p = 0; prev_de = 1'b0;
    for (int i = 0; i < FT; i++) begin
      if (frame_start) fs_n++;
      if (dpi_de) begin
        de_n++;
        run_len++;
        if (!prev_de) runs++;
      end else if (prev_de) begin
        check({tag, "_de_run_len"}, run_len, 8);
        run_len = 0;
      end
      prev_de = dpi_de;
      if (!dpi_hsync) hs_lo++;
      if (!dpi_vsync) vs_lo++;
      if (src.ready) rdy++;
      if (src.ready && src.valid) took++;
      if (p_hsync) hs_p++;
      if (p_vsync) vs_p++;
      @(negedge clk);
    end
    check({tag, "_frame_starts"}, fs_n, 1);
    check({tag, "_de_clocks"}, de_n, 32);
    check({tag, "_de_runs"}, runs, 4);
    check({tag, "_hsync_low"}, hs_lo, 14);
    check({tag, "_vsync_low"}, vs_lo, 14);
    check({tag, "_ready_clocks"}, rdy, 8);
    check({tag, "_words_taken"}, took, 8);
    check({tag, "_pol_hsync_high"}, hs_p, 14);
    check({tag, "_pol_vsync_high"}, vs_p, 14);
  endtask

  localparam logic [30:0] RESET_OUT = {1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0};

  initial begin
    int n, busy_n, fs_n, p, got;

    vec[0].word = 32'h44332211; vec[0].exp = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    vec[1].word = 32'hFF00A55A; vec[1].exp = {24'hFFFFFF, 24'h000000, 24'hA5A5A5, 24'h5A5A5A};
    vec[2].word = 32'h01020304; vec[2].exp = {24'h010101, 24'h020202, 24'h030303, 24'h040404};
    vec[3].word = 32'h80FF7F01; vec[3].exp = {24'h808080, 24'hFFFFFF, 24'h7F7F7F, 24'h010101};

    rst_n = 1'b1; en = 1'b0;
    src.valid = 1'b1; src.pixel = 32'h44332211;
    src_p.valid = 1'b1; src_p.pixel = 32'hA5A5A5A5;
    #2 rst_n = 1'b0;

    // Reset and idle with en=0
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {frame_start, dpi_vsync, dpi_hsync, dpi_de, dpi_pixel, underflow, busy, src.ready}, RESET_OUT);
    check("reset_pol_syncs", {p_hsync, p_vsync}, 2'b00);
    rst_n = 1'b1;
    mon_on = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_en0",
          {frame_start, dpi_vsync, dpi_hsync, dpi_de, dpi_pixel, underflow, busy, src.ready}, RESET_OUT);

    // Enable: frame_start with the first RUN clock, busy two clocks after en
    en = 1'b1;
    @(negedge clk);
    check("first_frame_start", frame_start, 1'b1);
    check("busy_after_1clk", busy, 1'b0);
    @(negedge clk);
    check("busy_after_2clk", busy, 1'b1);
    measure_frame("t1");
    check("t2_no_underflow", underflow, 1'b0);

    // Pixel order for several words, first active line of the frame after each change
    for (int i = 0; i < 4; i++) begin
      src.pixel = vec[i].word;
      wait_fs("tv_frame_sync");
      got = 0;
      n = 0;
      while (got < 8 && n < 40) begin
        @(negedge clk);
        n++;
        if (dpi_de) begin
          check($sformatf("tv%0d_pix%0d", i, got), dpi_pixel, vec[i].exp[got % 4]);
          got++;
        end
      end
      check("tv_collected", got, 8);
    end
    check("t2_underflow_still_0", underflow, 1'b0);

    // Drop s_valid for the second fetch of line 2
    src.pixel = 32'h44332211;
    wait_fs("t3_frame_sync");
    for (int c = 0; c < FT; c++) begin
      p = m.t - 1;
      if (p >= 0 && p / HT == 2 && p % HT >= 3 && p % HT <= 7)
        check($sformatf("t3_line2_h%0d", p % HT), {dpi_de, dpi_pixel},
              {1'b1, (p % HT == 3) ? 24'h444444 : 24'h000000});
      src.valid = (m.t != 2 * HT + 4);
      @(negedge clk);
    end
    src.valid = 1'b1;
    check("t3_underflow_set", underflow, 1'b1);
    wait_fs("t3_next_frame");
    repeat (FT / 2) @(negedge clk);
    check("t3_underflow_sticky", underflow, 1'b1);

    // en dropped mid-frame: the frame completes, then IDLE
    wait_fs("t4_frame_sync");
    repeat (40) @(negedge clk);
    en = 1'b0;
    busy_n = 0; fs_n = 0; n = 0;
    while (busy === 1'b1 && n < 300) begin
      busy_n++;
      if (frame_start) fs_n++;
      @(negedge clk);
      n++;
    end
    check("t4_busy_clocks_left", busy_n, 59);
    check("t4_no_frame_start", fs_n, 0);
    fs_n = 0; busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (frame_start) fs_n++;
      if (busy) busy_n++;
      @(negedge clk);
    end
    check("t4_idle_no_fs", fs_n, 0);
    check("t4_idle_busy", busy_n, 0);
    check("t4_idle_syncs", {dpi_hsync, dpi_vsync, p_hsync, p_vsync}, 4'b1100);
    en = 1'b1;
    @(negedge clk);
    check("t4_restart_fs", {frame_start, busy}, 2'b10);
    @(negedge clk);
    check("t4_restart_busy", busy, 1'b1);

    // Asynchronous reset at h=5, v=2
    n = 0;
    while (m.t != 2 * HT + 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_h5_v2", m.t, 2 * HT + 5);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset",
             {frame_start, dpi_vsync, dpi_hsync, dpi_de, dpi_pixel, underflow, busy, src.ready}, RESET_OUT);
    check("t5_async_reset_pol", {p_hsync, p_vsync}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_fs_after_reset", frame_start, 1'b1);
    @(negedge clk);
    measure_frame("t5");

    // Randomised traffic against the model
    for (int c = 0; c < 1500; c++) begin
      src.valid = ($urandom_range(0, 9) != 0);
      src.pixel = $urandom;
      if ($urandom_range(0, 199) == 0) en = ~en;
      @(negedge clk);
    end

    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
